// File: rtl/pn_conflict_arbiter.sv
// Shared Petri-net place with round-robin arbitration among N competing consumer transitions.
// Holds the token count, accepts upstream deposits and grants at most one consumer per cycle.
module pn_conflict_arbiter #(
    parameter int N   = 4,
    parameter int CAP = 3,
    localparam int CW = $clog2(CAP + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          put,
    output logic          put_ack,
    input  logic [N-1:0]  req,
    input  logic          hold,
    output logic [N-1:0]  grant,
    output logic [CW-1:0] tokens,
    output logic          empty,
    output logic          full,
    output logic [7:0]    fire_cnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] tokens_q, tokens_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [7:0]    fire_cnt_q, fire_cnt_d;

    logic          fire;
    logic          win_found;
    logic [PW-1:0] win_idx;
    logic [PW:0]   scan_idx;

    assign empty    = (tokens_q == '0);
    assign full     = (tokens_q == CW'(CAP));
    assign tokens   = tokens_q;
    assign grant    = grant_q;
    assign fire_cnt = fire_cnt_q;

    // put_ack is forced low during reset so a deposit cannot be acknowledged and then lost
    assign put_ack = put & ~full & rst;
    assign fire    = (|req) & ~empty & ~hold;

    // Scan requesters starting at the rotating pointer, wrapping modulo N
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int off = 0; off < N; off++) begin
            scan_idx = {1'b0, ptr_q} + (PW+1)'(off);
            if (scan_idx >= (PW+1)'(N)) begin
                scan_idx = scan_idx - (PW+1)'(N);
            end
            if (!win_found && req[scan_idx[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        grant_d    = '0;
        ptr_d      = ptr_q;
        fire_cnt_d = fire_cnt_q;
        tokens_d   = tokens_q;
        if (fire && win_found) begin
            grant_d[win_idx] = 1'b1;
            ptr_d            = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
            fire_cnt_d       = fire_cnt_q + 8'd1;
        end
        // Simultaneous deposit and fire leave the count unchanged
        if (put_ack && !fire) begin
            tokens_d = tokens_q + CW'(1);
        end else if (!put_ack && fire) begin
            tokens_d = tokens_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tokens_q   <= '0;
            grant_q    <= '0;
            ptr_q      <= '0;
            fire_cnt_q <= '0;
        end else begin
            tokens_q   <= tokens_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            fire_cnt_q <= fire_cnt_d;
        end
    end

endmodule

// File: tb/tb_pn_conflict_arbiter.sv
// Scoreboard bench for pn_conflict_arbiter: a driver steps a token/pointer reference model and
// queues per-cycle expectations that a monitor compares against the DUT after each edge.
module tb_pn_conflict_arbiter;

    localparam int N   = 4;
    localparam int CAP = 3;
    localparam int CW  = $clog2(CAP + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          put;
    logic          put_ack;
    logic [N-1:0]  req;
    logic          hold;
    logic [N-1:0]  grant;
    logic [CW-1:0] tokens;
    logic          empty;
    logic          full;
    logic [7:0]    fire_cnt;

    typedef struct {
        logic [N-1:0] grant;
        int           tokens;
        int           fc;
    } exp_t;

    exp_t sbQ[$];
    int checks = 0;
    int errors = 0;
    int mTok = 0;
    int mPtr = 0;
    int mFc  = 0;

    pn_conflict_arbiter #(.N(N), .CAP(CAP)) dut (
        .clk(clk), .rst(rst), .put(put), .put_ack(put_ack), .req(req), .hold(hold),
        .grant(grant), .tokens(tokens), .empty(empty), .full(full), .fire_cnt(fire_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive, check the combinational ack, advance the model, queue result
    task automatic applyStimulus(input bit p, input logic [N-1:0] r, input bit h);
        bit ack;
        bit f;
        bit found;
        int i;
        logic [N-1:0] g;
        @(negedge clk);
        put  = p;
        req  = r;
        hold = h;
        #1;
        ack = p && (mTok < CAP);
        checkOutput("put_ack", {31'b0, put_ack}, {31'b0, ack});
        f = (r != '0) && (mTok > 0) && !h;
        g = '0;
        if (f) begin
            found = 0;
            for (int off = 0; off < N; off++) begin
                i = (mPtr + off) % N;
                if (!found && r[i]) begin
                    found = 1;
                    g[i]  = 1'b1;
                end
            end
            for (int k = 0; k < N; k++) if (g[k]) mPtr = (k + 1) % N;
            mFc = (mFc + 1) % 256;
        end
        mTok = mTok + int'(ack) - int'(f);
        sbQ.push_back('{g, mTok, mFc});
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_grant"}, {28'b0, grant}, 32'd0);
        checkOutput({tag, "_tokens"}, {30'b0, tokens}, 32'd0);
        checkOutput({tag, "_fire_cnt"}, {24'b0, fire_cnt}, 32'd0);
        checkOutput({tag, "_empty"}, {31'b0, empty}, 32'd1);
        checkOutput({tag, "_full"}, {31'b0, full}, 32'd0);
        checkOutput({tag, "_put_ack"}, {31'b0, put_ack}, 32'd0);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst  = 1'b1;
        put  = 1'b0;
        req  = '0;
        mTok = 0;
        mPtr = 0;
        mFc  = 0;
    endtask

    // Monitor: after every edge compare the DUT against the oldest queued expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("grant", {28'b0, grant}, {28'b0, e.grant});
            checkOutput("tokens", {30'b0, tokens}, e.tokens);
            checkOutput("fire_cnt", {24'b0, fire_cnt}, e.fc);
            checkOutput("empty", {31'b0, empty}, {31'b0, e.tokens == 0});
            checkOutput("full", {31'b0, full}, {31'b0, e.tokens == CAP});
        end else if (grant != '0) begin
            checkOutput("unexpected_grant", {28'b0, grant}, 32'd0);
        end
    end

    initial begin
        int waitCycles;
        rst  = 1'b0;
        put  = 1'b1;
        req  = '1;
        hold = 1'b0;
        #3;
        checkResetState("reset_async");
        repeat (2) @(posedge clk);
        #2;
        checkResetState("reset_clocked");
        releaseReset();
        repeat (2) applyStimulus(0, 4'b0000, 0);

        // Single requester
        repeat (2) applyStimulus(1, 4'b0100, 0);
        repeat (3) applyStimulus(0, 4'b0100, 0);

        // Round robin with refill
        repeat (3) applyStimulus(1, 4'b0000, 0);
        repeat (3) applyStimulus(0, 4'b1111, 0);
        repeat (3) applyStimulus(1, 4'b0000, 0);
        repeat (3) applyStimulus(0, 4'b1111, 0);

        // Full place with simultaneous deposit and fire
        repeat (3) applyStimulus(1, 4'b0000, 0);
        repeat (2) applyStimulus(1, 4'b0001, 0);
        repeat (3) applyStimulus(0, 4'b0001, 0);

        // Hold freezes arbitration but still accepts deposits
        repeat (2) applyStimulus(1, 4'b0000, 0);
        applyStimulus(1, 4'b0011, 1);
        repeat (4) applyStimulus(0, 4'b0011, 1);
        repeat (4) applyStimulus(0, 4'b0011, 0);

        // Asynchronous reset while a grant pulse is active
        repeat (2) applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b0010, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkResetState("reset_midstream");
        sbQ.delete();
        repeat (2) @(posedge clk);
        releaseReset();
        applyStimulus(1, 4'b1111, 0);
        repeat (2) applyStimulus(0, 4'b1111, 0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'($urandom % 2), N'($urandom), ($urandom % 8) == 0);
        end
        applyStimulus(0, 4'b0000, 0);

        waitCycles = 0;
        while (sbQ.size() > 0 && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("scoreboard_drained", sbQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pn_conflict_arbiter.md
# pn_conflict_arbiter

Arbitrates a shared Petri-net place between N competing output transitions, the free-choice conflict case that the generated token nets cannot resolve on their own. It holds the place's token count, accepts token deposits from the upstream transition, and grants at most one downstream transition per cycle in round-robin order. It sits between a generated net's input transition logic and the transitions that consume from the shared place.

## Interface
- N, 4, number of competing consumer transitions (2..16)
- CAP, 3, place capacity in tokens (1..255)
- CW, $clog2(CAP+1), token counter width (derived, not overridden)
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- put  input  1  upstream transition requests to deposit one token
- put_ack  output  1  combinational: deposit accepted this cycle
- req  input  N  req[i]=1: transition i has all other input places marked and wants to fire
- hold  input  1  1 = suppress all grants (configuration freeze); deposits still accepted
- grant  output  N  registered one-hot, one-cycle pulse: transition i fired
- tokens  output  CW  current token count
- empty  output  1  tokens==0
- full  output  1  tokens==CAP
- fire_cnt  output  8  total grants since reset, wraps 255->0

## Operation
- Reset (rst low, asynchronous): tokens=0, grant=0, fire_cnt=0, rr pointer=0; hence empty=1, full=0, put_ack=0 while rst low.
- put_ack = put & !full, using the registered count; a fire in the same cycle does not free space for a deposit that cycle.
- fire condition (cycle k): |req & !empty & !hold.
- Winner: first i with req[i]=1 scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
- On fire: grant[winner]=1 for cycle k+1 only; ptr <= (winner+1) mod N; fire_cnt increments by 1 modulo 256.
- No fire: grant=0, ptr unchanged.
- Token update at edge ending cycle k: tokens <= tokens + put_ack - fire; both asserted means count unchanged.
- Counter never exceeds CAP and never underflows; no other paths modify it.
- req bits are level; a requester that keeps req high after grant stays eligible and competes again at its rotated priority.
- hold=1: no fire and ptr frozen; releasing hold resumes arbitration from the frozen ptr.
- Out-of-range requesters: none, req is exactly N bits. req=0 with tokens>0: tokens retained indefinitely.

## Timing
- Decision latency: 1 cycle; req sampled in cycle k, grant visible in cycle k+1.
- tokens/empty/full update at the same edge grant rises.
- Max throughput: 1 grant per cycle while tokens>0; sustained 1 put + 1 grant per cycle holds count constant.
- Deposit to first possible grant: put accepted in cycle k, tokens nonzero in k+1, grant in k+2.
- rst asserted mid-operation clears grant immediately (asynchronously), so no partial pulse survives; a token in flight is discarded. First grant after release no earlier than 2 cycles after first accepted put.
- empty, full, tokens, fire_cnt are register-driven; only put_ack is combinational (from put and full).

## Test plan
- Reset: rst low with put=1, req=4'b1111 -> grant=0, tokens=0, empty=1, put_ack=0, fire_cnt=0; after release outputs remain idle until put.
- Single requester: N=4, CAP=3, put for 2 cycles, req=4'b0100 held -> put_ack for both cycles, grant=4'b0100 exactly twice in consecutive cycles, tokens 0->1->1->0, fire_cnt=2, then grant=0 with req still high.
- Round-robin: tokens=3, req=4'b1111 -> grants 0001, 0010, 0100 in successive cycles; refill 3, grants continue 1000, 0001, 0010.
- Full/simultaneous: fill to 3 (full=1), put=1 with req=4'b0001 -> put_ack=0 first cycle, tokens drops to 2; next cycle put_ack=1 with grant again, tokens stays 2.
- Hold: tokens=2, req=4'b0011, hold=1 for 5 cycles -> no grants, tokens=2, put still accepted to 3; hold=0 -> grant=0001 next cycle.
- Async reset mid-stream: tokens=2, grant active, drop rst between edges -> grant, tokens, fire_cnt go 0 without a clock edge; ptr back to 0 (first post-reset grant with req=1111 is 0001).
